// File: rtl/bnn_image_sequencer.sv
// Streams one image of pixels into the bnn activation memory, kicks bnn, waits for done
// (bounded by a timeout) and returns the classification tagged with a running image index.
module bnn_image_sequencer #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 11,
    parameter int IMAGE_SIZE   = 784,
    parameter int RESULT_W     = 8,
    parameter int IDX_W        = 8,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 2**20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_last,
    output logic                bnn_wr_en,
    output logic [ADDR_W-1:0]   bnn_wr_addr,
    output logic [DATA_W-1:0]   bnn_wr_data,
    output logic                bnn_start,
    input  logic                bnn_done,
    input  logic [RESULT_W-1:0] bnn_result,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [RESULT_W-1:0] m_result,
    output logic [IDX_W-1:0]    m_index,
    output logic                m_len_err,
    output logic                m_timeout,
    output logic                busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_PAD    = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_RESULT = 3'd5;

    localparam int SC_W = $clog2(START_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_SIZE - 1);
    localparam logic [SC_W-1:0]   SC_END    = SC_W'(START_CYCLES);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    logic [2:0]        state, state_nxt;
    logic [ADDR_W-1:0] wr_cnt, beat_addr;
    logic [SC_W-1:0]   sc;
    logic [TO_W-1:0]   tcnt;
    logic              done_q, done_rise, ready_en, accept;

    // ready_en keeps s_ready low while reset is held and releases it one cycle later
    assign s_ready   = ready_en && (state == S_IDLE || state == S_LOAD);
    assign accept    = s_valid && s_ready;
    assign beat_addr = (state == S_LOAD) ? wr_cnt : '0;
    // done_q follows bnn_done in every state, so a level already high at RUN entry never looks like an edge
    assign done_rise = bnn_done && !done_q;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_LOAD: begin
                if (accept) begin
                    if (beat_addr == LAST_ADDR) state_nxt = S_START;
                    else if (s_last)            state_nxt = S_PAD;
                    else                        state_nxt = S_LOAD;
                end
            end
            S_PAD:    if (wr_cnt == LAST_ADDR) state_nxt = S_START;
            S_START:  if (sc == SC_END) state_nxt = S_RUN;
            S_RUN:    if (done_rise || tcnt == TO_LAST) state_nxt = S_RESULT;
            S_RESULT: if (m_valid && m_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            ready_en    <= 1'b0;
            done_q      <= 1'b0;
            wr_cnt      <= '0;
            sc          <= '0;
            tcnt        <= '0;
            bnn_wr_en   <= 1'b0;
            bnn_wr_addr <= '0;
            bnn_wr_data <= '0;
            bnn_start   <= 1'b0;
            m_valid     <= 1'b0;
            m_result    <= '0;
            m_index     <= '0;
            m_len_err   <= 1'b0;
            m_timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != S_IDLE);
            ready_en  <= 1'b1;
            done_q    <= bnn_done;
            bnn_wr_en <= 1'b0;
            bnn_start <= 1'b0;
            case (state)
                S_IDLE, S_LOAD: begin
                    if (accept) begin
                        bnn_wr_en   <= 1'b1;
                        bnn_wr_addr <= beat_addr;
                        bnn_wr_data <= s_data;
                        wr_cnt      <= beat_addr + 1'b1;
                        // a full-length beat without s_last still closes the image
                        if (beat_addr == LAST_ADDR) m_len_err <= !s_last;
                        else if (s_last)            m_len_err <= 1'b1;
                    end
                end
                S_PAD: begin
                    bnn_wr_en   <= 1'b1;
                    bnn_wr_addr <= wr_cnt;
                    bnn_wr_data <= '0;
                    wr_cnt      <= wr_cnt + 1'b1;
                end
                S_START: begin
                    wr_cnt <= '0;
                    if (sc == SC_END) begin
                        sc   <= '0;
                        tcnt <= '0;
                    end else begin
                        bnn_start <= 1'b1;
                        sc        <= sc + 1'b1;
                    end
                end
                S_RUN: begin
                    if (done_rise) begin
                        m_result  <= bnn_result;
                        m_timeout <= 1'b0;
                        m_valid   <= 1'b1;
                    end else if (tcnt == TO_LAST) begin
                        m_result  <= '0;
                        m_timeout <= 1'b1;
                        m_valid   <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_RESULT: begin
                    if (m_valid && m_ready) begin
                        m_valid <= 1'b0;
                        m_index <= m_index + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
